// File: rtl/lsu_mem_stage_if.sv
// Bus bundle between the LSU and its neighbours: MEM-stage request, writeback
// response and data-cache request/completion.
interface lsu_mem_stage_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [1:0]  req_width;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_ale;
    logic [31:0] resp_badv;
    logic        dc_valid;
    logic        dc_op;
    logic [31:0] dc_addr;
    logic [3:0]  dc_wstrb;
    logic [31:0] dc_wdata;
    logic        dc_data_valid;
    logic [31:0] dc_rdata;

    modport slave (
        input  req_valid, req_op, req_width, req_sext, req_addr, req_wdata, req_rd,
               flush, dc_data_valid, dc_rdata,
        output req_ready, resp_valid, resp_data, resp_rd, resp_ale, resp_badv,
               dc_valid, dc_op, dc_addr, dc_wstrb, dc_wdata
    );

    modport master (
        output req_valid, req_op, req_width, req_sext, req_addr, req_wdata, req_rd,
               flush, dc_data_valid, dc_rdata,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_ale, resp_badv,
               dc_valid, dc_op, dc_addr, dc_wstrb, dc_wdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit in front of the data cache: alignment check, byte mask, store
// replication, load extension. Optional counters under LSU_PERF_CNT_EN.
module lsu_mem_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_stage_if.slave   bus,
    output logic [CNT_W-1:0] perf_acc,
    output logic [CNT_W-1:0] perf_stall
);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t      state_q, state_d;
    logic        op_q, op_d, sext_q, sext_d;
    logic [1:0]  width_q, width_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [4:0]  rd_q, rd_d;
    logic        resp_valid_q, resp_valid_d, resp_ale_q, resp_ale_d;
    logic [31:0] resp_data_q, resp_data_d, resp_badv_q, resp_badv_d;
    logic [4:0]  resp_rd_q, resp_rd_d;

    logic        misaligned;
    logic [3:0]  strb_new;
    logic [31:0] wdata_new, lane, ld_ext;

    always_comb begin
        misaligned = 1'b0;
        strb_new   = 4'b1111;
        wdata_new  = bus.req_wdata;
        case (bus.req_width)
            2'd0: begin
                strb_new  = 4'b0001 << bus.req_addr[1:0];
                wdata_new = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                misaligned = bus.req_addr[0];
                strb_new   = 4'b0011 << bus.req_addr[1:0];
                wdata_new  = {2{bus.req_wdata[15:0]}};
            end
            default: misaligned = |bus.req_addr[1:0];
        endcase
    end

    // Aligned accesses only, so shifting the lane down to bit 0 covers both byte and half.
    assign lane = bus.dc_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (width_q)
            2'd0:    ld_ext = {{24{sext_q & lane[7]}}, lane[7:0]};
            2'd1:    ld_ext = {{16{sext_q & lane[15]}}, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        sext_d       = sext_q;
        width_d      = width_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rd_d         = rd_q;
        resp_valid_d = 1'b0;
        resp_ale_d   = resp_ale_q;
        resp_data_d  = resp_data_q;
        resp_badv_d  = resp_badv_q;
        resp_rd_d    = resp_rd_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    if (misaligned) begin
                        resp_valid_d = 1'b1;
                        resp_ale_d   = 1'b1;
                        resp_badv_d  = bus.req_addr;
                        resp_data_d  = '0;
                        resp_rd_d    = bus.req_rd;
                    end else begin
                        state_d = WAIT;
                        op_d    = bus.req_op;
                        sext_d  = bus.req_sext;
                        width_d = bus.req_width;
                        addr_d  = bus.req_addr;
                        wdata_d = wdata_new;
                        wstrb_d = strb_new;
                        rd_d    = bus.req_rd;
                    end
                end
            end
            WAIT: begin
                if (bus.dc_data_valid) begin
                    state_d = IDLE;
                    if (!bus.flush) begin
                        resp_valid_d = 1'b1;
                        resp_ale_d   = 1'b0;
                        resp_data_d  = op_q ? '0 : ld_ext;
                        resp_rd_d    = rd_q;
                    end
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: if (bus.dc_data_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 1'b0;
            sext_q       <= 1'b0;
            width_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rd_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_ale_q   <= 1'b0;
            resp_data_q  <= '0;
            resp_badv_q  <= '0;
            resp_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            sext_q       <= sext_d;
            width_q      <= width_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rd_q         <= rd_d;
            resp_valid_q <= resp_valid_d;
            resp_ale_q   <= resp_ale_d;
            resp_data_q  <= resp_data_d;
            resp_badv_q  <= resp_badv_d;
            resp_rd_q    <= resp_rd_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.dc_valid   = (state_q != IDLE);
    assign bus.dc_op      = op_q;
    assign bus.dc_addr    = addr_q;
    assign bus.dc_wstrb   = wstrb_q;
    assign bus.dc_wdata   = wdata_q;
    // A flush while an alignment fault is being reported kills that report.
    assign bus.resp_valid = resp_valid_q & ~(resp_ale_q & bus.flush);
    assign bus.resp_ale   = resp_ale_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_badv  = resp_badv_q;
    assign bus.resp_rd    = resp_rd_q;

`ifdef LSU_PERF_CNT_EN
    logic [CNT_W-1:0] acc_q, acc_d, stall_q, stall_d;

    always_comb begin
        acc_d   = acc_q + CNT_W'(state_q == IDLE && state_d == WAIT);
        stall_d = stall_q + CNT_W'(state_q != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            stall_q <= '0;
        end else begin
            acc_q   <= acc_d;
            stall_q <= stall_d;
        end
    end

    assign perf_acc   = acc_q;
    assign perf_stall = stall_q;
`else
    assign perf_acc   = '0;
    assign perf_stall = '0;
`endif
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized bench for lsu_mem_stage against a transaction-level model.
module tb_lsu_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] perf_acc, perf_stall;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    lsu_mem_stage_if bus();
    lsu_mem_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .perf_acc(perf_acc), .perf_stall(perf_stall)
    );

    // model: one outstanding cache access, and whether its result is still wanted
    bit          m_busy, m_keep, m_op, m_sext;
    int          m_size;
    logic [31:0] m_addr, m_wdata;
    logic [4:0]  m_rd;
    bit          e_vld, e_ale;
    logic [31:0] e_data, e_badv;
    logic [4:0]  e_rd;
    int unsigned n_acc, n_stall;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] rdata, input logic [31:0] addr,
                                             input int size, input bit sx);
        longint v, top;
        logic [63:0] r;
        top = longint'(1) << (8 * size);
        v   = (longint'(rdata) >> (8 * (addr % 4))) % top;
        if (sx && v >= top / 2) v = v - top;
        r = 64'(v);
        return r[31:0];
    endfunction

    function automatic logic [31:0] exp_strb();
        int t;
        t = ((1 << m_size) - 1) << (m_addr % 4);
        return 32'(t % 16);
    endfunction

    function automatic logic [31:0] exp_wdata();
        if (m_size == 1) return (m_wdata % 256) * 32'h0101_0101;
        if (m_size == 2) return (m_wdata % 65536) * 32'h0001_0001;
        return m_wdata;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_keep = 0; e_vld = 0; e_ale = 0; n_acc = 0; n_stall = 0;
    endtask

    task automatic check_perf();
`ifdef LSU_PERF_CNT_EN
        chk("perf_acc", perf_acc, n_acc);
        chk("perf_stall", perf_stall, n_stall);
`else
        chk("perf_acc", perf_acc, 0);
        chk("perf_stall", perf_stall, 0);
`endif
    endtask

    // One clock: drive inputs, check outputs against the model, clock, advance the model.
    task automatic cyc(input bit vld, input bit op, input logic [1:0] w, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input bit fl, input bit dv, input logic [31:0] rdat);
        int sz;
        bus.req_valid = vld; bus.req_op = op; bus.req_width = w; bus.req_sext = sx;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_rd = rd; bus.flush = fl;
        bus.dc_data_valid = dv; bus.dc_rdata = rdat;
        #1;
        chk("req_ready", bus.req_ready, !m_busy);
        chk("dc_valid", bus.dc_valid, m_busy);
        if (m_busy) begin
            chk("dc_op", bus.dc_op, m_op);
            chk("dc_addr", bus.dc_addr, m_addr);
            chk("dc_wstrb", bus.dc_wstrb, exp_strb());
            chk("dc_wdata", bus.dc_wdata, exp_wdata());
        end
        chk("resp_valid", bus.resp_valid, e_vld && !(e_ale && fl));
        if (e_vld) begin
            chk("resp_ale", bus.resp_ale, e_ale);
            chk("resp_rd", bus.resp_rd, e_rd);
            chk("resp_data", bus.resp_data, e_data);
            if (e_ale) chk("resp_badv", bus.resp_badv, e_badv);
        end
        check_perf();
        @(posedge clk);
        if (m_busy) n_stall++;
        e_vld = 0;
        if (!m_busy) begin
            if (vld && !fl) begin
                sz = size_of(w);
                if (a % sz != 0) begin
                    e_vld = 1; e_ale = 1; e_badv = a; e_data = 0; e_rd = rd;
                end else begin
                    m_busy = 1; m_keep = 1; m_op = op; m_size = sz; m_sext = sx;
                    m_addr = a; m_wdata = wd; m_rd = rd; n_acc++;
                end
            end
        end else begin
            if (fl) m_keep = 0;
            if (dv) begin
                m_busy = 0;
                if (m_keep) begin
                    e_vld = 1; e_ale = 0; e_rd = m_rd;
                    e_data = m_op ? 32'h0 : load_val(rdat, m_addr, m_size, m_sext);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input bit fl, input bit dv, input logic [31:0] rdat);
        cyc(0, 0, 2'd0, 0, 32'h0, 32'h0, 5'd0, fl, dv, rdat);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 0; bus.req_op = 0; bus.req_width = 0; bus.req_sext = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.req_rd = 0; bus.flush = 0;
        bus.dc_data_valid = 0; bus.dc_rdata = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_dc_valid", bus.dc_valid, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_dc_wstrb", bus.dc_wstrb, 0);
        chk("rst_dc_addr", bus.dc_addr, 0);
        check_perf();
        rst = 1'b0;

        // signed byte load from the top lane, cache done after 3 cycles
        cyc(1, 0, 2'd0, 1, 32'h1003, 32'h0, 5'd5, 0, 0, 0);
        chk("ldb_wstrb", bus.dc_wstrb, 4'b1000);
        idle(0, 0, 0);
        idle(0, 0, 0);
        idle(0, 1, 32'h80FF_1234);
        chk("ldb_resp_valid", bus.resp_valid, 1);
        chk("ldb_resp_data", bus.resp_data, 32'hFFFF_FF80);
        chk("ldb_req_ready", bus.req_ready, 1);
        idle(0, 0, 0);

        // halfword store to upper half
        cyc(1, 1, 2'd1, 0, 32'h2002, 32'h0000_ABCD, 5'd6, 0, 0, 0);
        chk("sth_op", bus.dc_op, 1);
        chk("sth_wstrb", bus.dc_wstrb, 4'b1100);
        chk("sth_wdata", bus.dc_wdata, 32'hABCD_ABCD);
        idle(0, 1, 32'h1234_5678);
        chk("sth_resp_valid", bus.resp_valid, 1);
        chk("sth_resp_data", bus.resp_data, 0);

        // misaligned word load
        cyc(1, 0, 2'd2, 0, 32'h3002, 32'h0, 5'd7, 0, 0, 0);
        chk("ale_dc_valid", bus.dc_valid, 0);
        chk("ale_flag", bus.resp_ale, 1);
        chk("ale_badv", bus.resp_badv, 32'h3002);
        chk("ale_req_ready", bus.req_ready, 1);
        idle(0, 0, 0);
        // a flush while the fault is being reported suppresses it
        cyc(1, 0, 2'd1, 0, 32'h3001, 32'h0, 5'd8, 0, 0, 0);
        idle(1, 0, 0);

        // unsigned half load flushed in its second WAIT cycle
        cyc(1, 0, 2'd1, 0, 32'h4002, 32'h0, 5'd9, 0, 0, 0);
        idle(0, 0, 0);
        idle(1, 0, 0);
        idle(0, 0, 0);
        idle(0, 0, 0);
        idle(0, 0, 0);
        chk("drain_dc_valid", bus.dc_valid, 1);
        idle(0, 1, 32'hDEAD_BEEF);
        chk("drain_no_resp", bus.resp_valid, 0);
        chk("drain_req_ready", bus.req_ready, 1);
        idle(0, 0, 0);

        // back-to-back with a one-cycle cache
        do_reset();
        cyc(1, 0, 2'd2, 0, 32'h10, 32'h0, 5'd1, 0, 0, 0);
        cyc(1, 1, 2'd0, 0, 32'h11, 32'h55, 5'd2, 0, 1, 32'h0102_0304);
        chk("b2b_ready", bus.req_ready, 1);
        cyc(1, 1, 2'd0, 0, 32'h11, 32'h55, 5'd2, 0, 0, 0);
        chk("b2b_dc_addr", bus.dc_addr, 32'h11);
        idle(0, 1, 0);
`ifdef LSU_PERF_CNT_EN
        chk("b2b_perf_acc", perf_acc, 2);
        chk("b2b_perf_stall", perf_stall, 2);
`endif

        // reset while an access is in flight
        cyc(1, 0, 2'd2, 0, 32'h20, 32'h0, 5'd3, 0, 0, 0);
        chk("mid_dc_valid", bus.dc_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", bus.req_ready, 1);
        chk("mid_rst_dc_valid", bus.dc_valid, 0);
        chk("mid_rst_resp_valid", bus.resp_valid, 0);
        chk("mid_rst_wstrb", bus.dc_wstrb, 0);
        model_reset();
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3));
            cyc($urandom_range(0, 9) < 6, 1'($urandom), 2'($urandom), 1'($urandom),
                a, $urandom, 5'($urandom), $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 4, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
